// File: rtl/serv_lsu_serdes.sv
// Bit-serial load/store data stage: serialises store data onto a Wishbone-classic bus and
// aligns/extends load data back out one bit per enable. Optional trap: SERV_LSU_MISALIGN_TRAP_EN.
module serv_lsu_serdes (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_rs2,
    input  logic [31:0] i_adr,
    input  logic [1:0]  i_lsb,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic        o_rd,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_misalign,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] READ = 2'd2;

    logic [1:0]  state;
    logic [31:0] dat;
    logic [4:0]  bitcnt;
    logic [1:0]  size_r;
    logic [1:0]  lsb_r;
    logic        signed_r;
    logic        sign;
    logic        misalign_q;
    logic        trap;
    logic [3:0]  sel_nxt;
    logic [5:0]  width;
    logic        below_w;

`ifdef SERV_LSU_MISALIGN_TRAP_EN
    assign trap = (i_size == 2'b01 && i_lsb[0]) || (i_size[1] && i_lsb != 2'b00);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        sel_nxt = 4'b1111;
        case (i_size)
            2'b00:   sel_nxt = 4'b0001 << i_lsb;
            2'b01:   sel_nxt = i_lsb[1] ? 4'b1100 : 4'b0011;
            default: sel_nxt = 4'b1111;
        endcase
    end

    always_comb begin
        width    = 6'd32;
        o_wb_dat = dat;
        case (size_r)
            2'b00: begin width = 6'd8;  o_wb_dat = {4{dat[7:0]}};  end
            2'b01: begin width = 6'd16; o_wb_dat = {2{dat[15:0]}}; end
            default: ;
        endcase
    end

    assign below_w    = {1'b0, bitcnt} < width;
    assign o_busy     = state != IDLE;
    assign o_misalign = misalign_q;
    // Past the loaded width the result is pure extension: sign bit or zero.
    assign o_rd = (state == READ) && i_en && (below_w ? dat[0] : (signed_r & sign));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            dat        <= 32'd0;
            bitcnt     <= 5'd0;
            size_r     <= 2'd0;
            lsb_r      <= 2'd0;
            signed_r   <= 1'b0;
            sign       <= 1'b0;
            misalign_q <= 1'b0;
            o_done     <= 1'b0;
            o_wb_adr   <= 32'd0;
            o_wb_sel   <= 4'd0;
            o_wb_we    <= 1'b0;
            o_wb_stb   <= 1'b0;
        end else begin
            o_done     <= 1'b0;
            misalign_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_en)
                        dat <= {i_rs2, dat[31:1]};
                    if (i_req) begin
                        size_r   <= i_size;
                        lsb_r    <= i_lsb;
                        signed_r <= i_signed;
                        o_wb_we  <= i_we;
                        o_wb_adr <= {i_adr[31:2], 2'b00};
                        o_wb_sel <= sel_nxt;
                        if (trap)
                            misalign_q <= 1'b1;
                        else begin
                            o_wb_stb <= 1'b1;
                            state    <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (i_wb_ack && o_wb_stb) begin
                        o_wb_stb <= 1'b0;
                        o_done   <= 1'b1;
                        if (o_wb_we)
                            state <= IDLE;
                        else begin
                            dat    <= i_wb_rdt >> {lsb_r, 3'b000};
                            bitcnt <= 5'd0;
                            state  <= READ;
                        end
                    end
                end
                READ: begin
                    if (i_en) begin
                        if (below_w)
                            dat <= {1'b0, dat[31:1]};
                        if ({1'b0, bitcnt} == width - 6'd1)
                            sign <= dat[0];
                        bitcnt <= bitcnt + 5'd1;
                        if (bitcnt == 5'd31)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serv_lsu_serdes.sv
// Directed bench for serv_lsu_serdes: stores, aligned/extended loads, reset abort, misalignment.
module tb_serv_lsu_serdes;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_en = 1'b0, i_rs2 = 1'b0, i_req = 1'b0, i_we = 1'b0, i_signed = 1'b0;
    logic [31:0] i_adr = 32'd0, i_wb_rdt = 32'd0;
    logic [1:0]  i_lsb = 2'd0, i_size = 2'd0;
    logic        i_wb_ack = 1'b0;
    logic        o_rd, o_busy, o_done, o_misalign, o_wb_we, o_wb_stb;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;
    int checks = 0, errors = 0;

    serv_lsu_serdes dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_rs2(i_rs2), .i_adr(i_adr),
        .i_lsb(i_lsb), .i_req(i_req), .i_we(i_we), .i_size(i_size), .i_signed(i_signed),
        .o_rd(o_rd), .o_busy(o_busy), .o_done(o_done), .o_misalign(o_misalign),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_wb_stb(o_wb_stb), .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk); #1;
    endtask

    task automatic set_req(input logic we, input logic [1:0] size, input logic [1:0] lsb,
                           input logic sgn, input logic [31:0] adr);
        i_we = we; i_size = size; i_lsb = lsb; i_signed = sgn; i_adr = adr;
    endtask

    // Shift a word in LSB first; optionally raise i_req on the final enable.
    task automatic shift_word(input logic [31:0] d, input logic req_last);
        for (int i = 0; i < 32; i++) begin
            i_en = 1'b1; i_rs2 = d[i];
            i_req = (i == 31) && req_last;
            step();
        end
        i_en = 1'b0; i_req = 1'b0;
    endtask

    task automatic do_ack(input logic [31:0] rdt);
        i_wb_rdt = rdt; i_wb_ack = 1'b1;
        step();
        i_wb_ack = 1'b0;
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL ack_done got %b exp 1", o_done); end
        checks++; if (o_wb_stb !== 1'b0) begin errors++; $display("FAIL ack_stb got %b exp 0", o_wb_stb); end
    endtask

    task automatic read_word(output logic [31:0] r);
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            i_en = 1'b1; #1;
            r[i] = o_rd;
            @(posedge i_clk); #1;
        end
        i_en = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (o_wb_stb !== 1'b0) begin errors++; $display("FAIL rst_stb got %b exp 0", o_wb_stb); end
        checks++; if (o_done !== 1'b0 || o_busy !== 1'b0 || o_rd !== 1'b0 || o_misalign !== 1'b0) begin
            errors++; $display("FAIL rst_ctl got %b%b%b%b exp 0000", o_done, o_busy, o_rd, o_misalign); end
        checks++; if (o_wb_adr !== 32'd0 || o_wb_sel !== 4'd0 || o_wb_we !== 1'b0 || o_wb_dat !== 32'd0) begin
            errors++; $display("FAIL rst_bus got %h %h %b %h exp 0", o_wb_adr, o_wb_sel, o_wb_we, o_wb_dat); end
        @(posedge i_clk); #1; i_rst = 1'b0;
        step();
    endtask

    task automatic test_word_store();
        shift_word(32'hDEADBEEF, 1'b0);
        i_wb_ack = 1'b1; step(); i_wb_ack = 1'b0;  // stray ack in IDLE
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL idle_ack got %b exp 0", o_done); end
        set_req(1'b1, 2'b10, 2'd0, 1'b0, 32'h100);
        i_req = 1'b1; step(); i_req = 1'b0;
        checks++; if (o_wb_stb !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL ws_stb got %b%b exp 11", o_wb_stb, o_busy); end
        checks++; if (o_wb_adr !== 32'h100 || o_wb_sel !== 4'b1111 || o_wb_we !== 1'b1) begin
            errors++; $display("FAIL ws_bus got %h %b %b exp 100 1111 1", o_wb_adr, o_wb_sel, o_wb_we); end
        // enable and a new request while in BUS must not disturb the access
        i_en = 1'b1; i_rs2 = 1'b0; i_req = 1'b1; set_req(1'b0, 2'b00, 2'd1, 1'b0, 32'h400);
        step(); i_en = 1'b0; i_req = 1'b0;
        checks++; if (o_wb_dat !== 32'hDEADBEEF || o_wb_adr !== 32'h100 || o_wb_sel !== 4'b1111) begin
            errors++; $display("FAIL ws_hold got %h %h %b exp deadbeef 100 1111", o_wb_dat, o_wb_adr, o_wb_sel); end
        do_ack(32'h0);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ws_idle got %b exp 0", o_busy); end
        step();
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL ws_done_pulse got %b exp 0", o_done); end
    endtask

    task automatic test_byte_store();
        set_req(1'b1, 2'b00, 2'd3, 1'b0, 32'h2003);
        shift_word(32'h000000A5, 1'b1);  // request coincides with final shift
        checks++; if (o_wb_dat !== 32'hA5A5A5A5 || o_wb_sel !== 4'b1000) begin
            errors++; $display("FAIL bs got %h %b exp a5a5a5a5 1000", o_wb_dat, o_wb_sel); end
        checks++; if (o_wb_adr !== 32'h2000) begin errors++; $display("FAIL bs_adr got %h exp 2000", o_wb_adr); end
        do_ack(32'h0);
    endtask

    task automatic test_half_store();
        shift_word(32'h1234BEEF, 1'b0);
        set_req(1'b1, 2'b01, 2'd2, 1'b0, 32'h10);
        i_req = 1'b1; step(); i_req = 1'b0;
        checks++; if (o_wb_dat !== 32'hBEEFBEEF || o_wb_sel !== 4'b1100) begin
            errors++; $display("FAIL hs got %h %b exp beefbeef 1100", o_wb_dat, o_wb_sel); end
        do_ack(32'h0);
    endtask

    task automatic test_load(input string nm, input logic [1:0] size, input logic [1:0] lsb,
                             input logic sgn, input logic [31:0] rdt, input logic [3:0] sel,
                             input logic [31:0] exp);
        logic [31:0] r;
        set_req(1'b0, size, lsb, sgn, 32'h207);
        i_req = 1'b1; step(); i_req = 1'b0;
        checks++; if (o_wb_adr !== 32'h204 || o_wb_we !== 1'b0 || o_wb_sel !== sel) begin
            errors++; $display("FAIL %s_bus got %h %b %b exp 204 0 %b", nm, o_wb_adr, o_wb_we, o_wb_sel, sel); end
        do_ack(rdt);
        checks++; if (o_rd !== 1'b0) begin errors++; $display("FAIL %s_rd_noen got %b exp 0", nm, o_rd); end
        read_word(r);
        checks++; if (r !== exp) begin errors++; $display("FAIL %s got %h exp %h", nm, r, exp); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL %s_idle got %b exp 0", nm, o_busy); end
    endtask

    task automatic test_reset_bus();
        set_req(1'b1, 2'b10, 2'd0, 1'b0, 32'h300);
        i_req = 1'b1; step(); i_req = 1'b0;
        checks++; if (o_wb_stb !== 1'b1) begin errors++; $display("FAIL rb_stb got %b exp 1", o_wb_stb); end
        #2 i_rst = 1'b1; #1;
        checks++; if (o_wb_stb !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL rb_async got %b%b exp 00", o_wb_stb, o_busy); end
        @(posedge i_clk); #1; i_rst = 1'b0;
        i_wb_ack = 1'b1; step(); i_wb_ack = 1'b0;
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rb_nodone got %b exp 0", o_done); end
        shift_word(32'h12345678, 1'b0);
        i_req = 1'b1; step(); i_req = 1'b0;
        checks++; if (o_wb_stb !== 1'b1 || o_wb_dat !== 32'h12345678) begin
            errors++; $display("FAIL rb_after got %b %h exp 1 12345678", o_wb_stb, o_wb_dat); end
        do_ack(32'h0);
    endtask

    task automatic test_misalign();
        set_req(1'b1, 2'b10, 2'd2, 1'b0, 32'h500);
        i_req = 1'b1; step(); i_req = 1'b0;
`ifdef SERV_LSU_MISALIGN_TRAP_EN
        checks++; if (o_misalign !== 1'b1 || o_wb_stb !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL ma_trap got %b%b%b exp 100", o_misalign, o_wb_stb, o_busy); end
        step();
        checks++; if (o_misalign !== 1'b0 || o_done !== 1'b0) begin
            errors++; $display("FAIL ma_pulse got %b%b exp 00", o_misalign, o_done); end
`else
        checks++; if (o_wb_stb !== 1'b1 || o_wb_sel !== 4'b1111 || o_misalign !== 1'b0) begin
            errors++; $display("FAIL ma_issue got %b %b %b exp 1 1111 0", o_wb_stb, o_wb_sel, o_misalign); end
        do_ack(32'h0);
`endif
        // size 11 behaves as word
        set_req(1'b1, 2'b11, 2'd0, 1'b0, 32'h600);
        i_req = 1'b1; step(); i_req = 1'b0;
        checks++; if (o_wb_sel !== 4'b1111 || o_wb_stb !== 1'b1) begin
            errors++; $display("FAIL sz3 got %b %b exp 1111 1", o_wb_sel, o_wb_stb); end
        do_ack(32'h0);
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_store();
        test_half_store();
        test_load("ld_sb", 2'b00, 2'd2, 1'b1, 32'h0080_0000, 4'b0100, 32'hFFFFFF80);
        test_load("ld_ub", 2'b00, 2'd2, 1'b0, 32'h0080_0000, 4'b0100, 32'h00000080);
        test_load("ld_uh", 2'b01, 2'd2, 1'b0, 32'h8001_1234, 4'b1100, 32'h00008001);
        test_load("ld_sh", 2'b01, 2'd2, 1'b1, 32'h8001_1234, 4'b1100, 32'hFFFF8001);
        test_load("ld_w",  2'b10, 2'd0, 1'b1, 32'h8765_4321, 4'b1111, 32'h87654321);
        test_reset_bus();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
